// File: rtl/fnd_scan_driver.sv
// Four-digit multiplexed 7-segment (FND) scan driver.
// A slow scan level is synchronized into clk and edge-detected. Each rising
// edge advances the scanned digit using break-before-make: all anodes go off
// for one cycle while segments and index switch, then the new anode turns on.
// Display data is snapshotted at frame start so a frame never shows mixed data.
module fnd_scan_driver #(
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_scan_clk,
  input  logic [15:0] i_bcd,
  input  logic [3:0]  i_dp,
  input  logic        i_blank_lz,
  output logic [3:0]  o_an,
  output logic [7:0]  o_seg,
  output logic [1:0]  o_digit,
  output logic        o_frame_done
);

  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } state_t;

  // BCD to active-high segments {g,f,e,d,c,b,a}; non-decimal nibbles show "-".
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   scan_s;
  logic                   step_s;

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] bcd_r;
  logic [3:0]  dp_r;
  logic        blank_lz_r;
  logic        make_r;

  logic        capture_s;
  logic [1:0]  digit_next_s;
  logic [15:0] bcd_use_s;
  logic [3:0]  dp_use_s;
  logic        lz_use_s;
  logic [3:0]  nib_s;
  logic        blank_s;
  logic [7:0]  seg_hi_s;
  logic [3:0]  an_hi_s;
  logic        wrap_s;

  // Bring the scan level into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], i_scan_clk};
    end
  end

  // Remember the previous synchronized level for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= scan_s;
    end
  end

  assign scan_s = sync_r[SYNC_STAGES-1];
  assign step_s = scan_s & ~prev_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= BLANK;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: leave BLANK on the first step, then scan forever.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      BLANK: begin
        if (step_s) begin
          state_next_s = SCAN;
        end else begin
          state_next_s = BLANK;
        end
      end
      SCAN:    state_next_s = SCAN;
      default: state_next_s = BLANK;
    endcase
  end

  // Next digit, snapshot selection, decode and blanking for the upcoming digit.
  always_comb begin
    capture_s    = step_s & ((state_r == BLANK) | (o_digit == 2'd3));
    wrap_s       = step_s & (state_r == SCAN) & (o_digit == 2'd3);
    digit_next_s = (state_r == BLANK) ? 2'd0 : (o_digit + 2'd1);
    bcd_use_s    = capture_s ? i_bcd      : bcd_r;
    dp_use_s     = capture_s ? i_dp       : dp_r;
    lz_use_s     = capture_s ? i_blank_lz : blank_lz_r;
    nib_s        = 4'd0;
    blank_s      = 1'b0;
    case (digit_next_s)
      2'd3: begin
        nib_s   = bcd_use_s[15:12];
        blank_s = lz_use_s & (bcd_use_s[15:12] == 4'd0);
      end
      2'd2: begin
        nib_s   = bcd_use_s[11:8];
        blank_s = lz_use_s & (bcd_use_s[15:8] == 8'd0);
      end
      2'd1: begin
        nib_s   = bcd_use_s[7:4];
        blank_s = lz_use_s & (bcd_use_s[15:4] == 12'd0);
      end
      2'd0: begin
        nib_s   = bcd_use_s[3:0];
        blank_s = 1'b0;
      end
      default: begin
        nib_s   = 4'd0;
        blank_s = 1'b0;
      end
    endcase
    seg_hi_s = {dp_use_s[digit_next_s], (blank_s ? 7'h00 : bcd_to_seg(nib_s))};
    an_hi_s  = 4'b0001 << o_digit;
  end

  // Snapshot display data at frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_r      <= 16'h0000;
      dp_r       <= 4'h0;
      blank_lz_r <= 1'b0;
    end else if (capture_s) begin
      bcd_r      <= i_bcd;
      dp_r       <= i_dp;
      blank_lz_r <= i_blank_lz;
    end
  end

  // Output stage: break on the step, make one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_an         <= AN_OFF;
      o_seg        <= SEG_OFF;
      o_digit      <= 2'd0;
      o_frame_done <= 1'b0;
      make_r       <= 1'b0;
    end else if (step_s) begin
      o_an         <= AN_OFF;
      o_seg        <= ACTIVE_LOW ? ~seg_hi_s : seg_hi_s;
      o_digit      <= digit_next_s;
      o_frame_done <= wrap_s;
      make_r       <= 1'b1;
    end else begin
      o_frame_done <= 1'b0;
      if (make_r) begin
        o_an   <= ACTIVE_LOW ? ~an_hi_s : an_hi_s;
        make_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed self-checking bench for fnd_scan_driver (defaults: 2 sync stages, active-low).
module tb_fnd_scan_driver;

  logic        clk;
  logic        reset;
  logic        i_scan_clk;
  logic [15:0] i_bcd;
  logic [3:0]  i_dp;
  logic        i_blank_lz;
  logic [3:0]  o_an;
  logic [7:0]  o_seg;
  logic [1:0]  o_digit;
  logic        o_frame_done;

  int checks;
  int errors;

  // Values captured by do_step: k = clock edge index after scan goes high.
  logic [3:0] an_k2, an_k3, an_k4;
  logic [7:0] seg_k3;
  logic [1:0] dig_k3;
  logic       fd_k3;
  int         fd_cnt;
  int         off_cnt;

  fnd_scan_driver #(.SYNC_STAGES(2), .ACTIVE_LOW(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_scan_clk   (i_scan_clk),
    .i_bcd        (i_bcd),
    .i_dp         (i_dp),
    .i_blank_lz   (i_blank_lz),
    .o_an         (o_an),
    .o_seg        (o_seg),
    .o_digit      (o_digit),
    .o_frame_done (o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One scan rise held for 3 clk edges, then low; samples on each negedge.
  task automatic do_step();
    @(negedge clk);
    i_scan_clk = 1'b1;
    fd_cnt  = 0;
    off_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) i_scan_clk = 1'b0;
      if (o_frame_done) fd_cnt++;
      if (k >= 3 && o_an == 4'hF) off_cnt++;
      if (k == 2) an_k2 = o_an;
      if (k == 3) begin
        an_k3  = o_an;
        seg_k3 = o_seg;
        dig_k3 = o_digit;
        fd_k3  = o_frame_done;
      end
      if (k == 4) an_k4 = o_an;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_scan_clk = 1'b0;
    apply_reset();
    checks++; if (o_an !== 4'hF) begin errors++; $display("FAIL reset_an got %h exp %h", o_an, 4'hF); end
    checks++; if (o_seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h exp %h", o_seg, 8'hFF); end
    checks++; if (o_digit !== 2'd0) begin errors++; $display("FAIL reset_digit got %0d exp 0", o_digit); end
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", o_frame_done); end
  endtask

  task automatic test_basic_scan();
    logic [7:0] exp_seg [4];
    exp_seg[0] = 8'h99; exp_seg[1] = 8'hB0; exp_seg[2] = 8'hA4; exp_seg[3] = 8'hF9;
    i_bcd = 16'h1234; i_dp = 4'h0; i_blank_lz = 1'b0;
    apply_reset();
    for (int s = 0; s < 5; s++) begin
      logic [1:0] d;
      logic [3:0] exp_an;
      d = 2'(s % 4);
      exp_an = ~(4'b0001 << d);
      do_step();
      checks++; if (dig_k3 !== d) begin errors++; $display("FAIL basic_digit step %0d got %0d exp %0d", s, dig_k3, d); end
      checks++; if (seg_k3 !== exp_seg[d]) begin errors++; $display("FAIL basic_seg step %0d got %h exp %h", s, seg_k3, exp_seg[d]); end
      checks++; if (an_k3 !== 4'hF) begin errors++; $display("FAIL basic_break step %0d got %h exp F", s, an_k3); end
      checks++; if (an_k4 !== exp_an) begin errors++; $display("FAIL basic_make step %0d got %h exp %h", s, an_k4, exp_an); end
      checks++; if (off_cnt !== 1) begin errors++; $display("FAIL basic_offcycles step %0d got %0d exp 1", s, off_cnt); end
      checks++; if (fd_k3 !== (s == 4)) begin errors++; $display("FAIL basic_fd step %0d got %b exp %b", s, fd_k3, (s == 4)); end
      checks++; if (fd_cnt !== ((s == 4) ? 1 : 0)) begin errors++; $display("FAIL basic_fdcount step %0d got %0d", s, fd_cnt); end
      if (s > 0) begin
        logic [3:0] prev_an;
        prev_an = ~(4'b0001 << d - 2'd1);
        checks++; if (an_k2 !== prev_an) begin errors++; $display("FAIL basic_latency step %0d got %h exp %h", s, an_k2, prev_an); end
      end
    end
  endtask

  task automatic test_blanking();
    logic [7:0] exp_seg [4];
    exp_seg[0] = 8'hC0; exp_seg[1] = 8'h92; exp_seg[2] = 8'h7F; exp_seg[3] = 8'hFF;
    i_bcd = 16'h0050; i_dp = 4'b0100; i_blank_lz = 1'b1;
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      do_step();
      checks++; if (seg_k3 !== exp_seg[s]) begin errors++; $display("FAIL blank_seg digit %0d got %h exp %h", s, seg_k3, exp_seg[s]); end
      checks++; if (an_k4 !== ~(4'b0001 << s)) begin errors++; $display("FAIL blank_an digit %0d got %h", s, an_k4); end
    end
  endtask

  task automatic test_shadow();
    i_bcd = 16'h1111; i_dp = 4'h0; i_blank_lz = 1'b0;
    apply_reset();
    do_step();
    do_step();
    i_bcd = 16'h2222;
    do_step();
    checks++; if (seg_k3 !== 8'hF9) begin errors++; $display("FAIL shadow_d2 got %h exp F9", seg_k3); end
    do_step();
    checks++; if (seg_k3 !== 8'hF9) begin errors++; $display("FAIL shadow_d3 got %h exp F9", seg_k3); end
    do_step();
    checks++; if (seg_k3 !== 8'hA4) begin errors++; $display("FAIL shadow_next_d0 got %h exp A4", seg_k3); end
  endtask

  task automatic test_dash();
    i_bcd = 16'h00FA; i_dp = 4'b0001; i_blank_lz = 1'b0;
    apply_reset();
    do_step();
    checks++; if (seg_k3 !== 8'h3F) begin errors++; $display("FAIL dash_dp got %h exp 3F", seg_k3); end
    do_step();
    checks++; if (seg_k3 !== 8'hBF) begin errors++; $display("FAIL dash_f got %h exp BF", seg_k3); end
  endtask

  task automatic test_reset_mid();
    i_bcd = 16'h1234; i_dp = 4'h0; i_blank_lz = 1'b0;
    apply_reset();
    do_step(); do_step(); do_step();
    checks++; if (o_digit !== 2'd2) begin errors++; $display("FAIL mid_pre_digit got %0d exp 2", o_digit); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (o_an !== 4'hF) begin errors++; $display("FAIL mid_async_an got %h exp F", o_an); end
    checks++; if (o_seg !== 8'hFF) begin errors++; $display("FAIL mid_async_seg got %h exp FF", o_seg); end
    @(negedge clk);
    reset = 1'b0;
    do_step();
    checks++; if (dig_k3 !== 2'd0) begin errors++; $display("FAIL mid_restart_digit got %0d exp 0", dig_k3); end
    checks++; if (seg_k3 !== 8'h99) begin errors++; $display("FAIL mid_restart_seg got %h exp 99", seg_k3); end
    checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL mid_restart_fd got %0d exp 0", fd_cnt); end
  endtask

  task automatic test_reset_scan_high();
    i_bcd = 16'h0007; i_dp = 4'h0; i_blank_lz = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    i_scan_clk = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    checks++; if (o_an !== 4'hE) begin errors++; $display("FAIL high_release_an got %h exp E", o_an); end
    checks++; if (o_seg !== 8'hF8) begin errors++; $display("FAIL high_release_seg got %h exp F8", o_seg); end
    i_scan_clk = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    i_scan_clk = 1'b0;
    i_bcd = 16'h0000;
    i_dp = 4'h0;
    i_blank_lz = 1'b0;
    test_reset();
    test_basic_scan();
    test_blanking();
    test_shadow();
    test_dash();
    test_reset_mid();
    test_reset_scan_high();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
